// File: rtl/cdr_loop_ctrl.sv
// Bang-bang CDR loop controller: decimates PD votes per window and runs a PI filter that
// steers the phase-interpolator code through acquisition, tracking and lock detection.
module cdr_loop_ctrl #(
  parameter int unsigned PI_BITS    = 8,
  parameter int unsigned FRAC       = 4,
  parameter int unsigned DECIM      = 16,
  parameter int unsigned INT_W      = 16,
  parameter int unsigned KP_ACQ     = 4,
  parameter int unsigned KP_TRK     = 1,
  parameter int unsigned KI_SHIFT   = 4,
  parameter int unsigned ACQ_WIN    = 32,
  parameter int unsigned LOCK_THR   = 2,
  parameter int unsigned LOCK_WIN   = 8,
  parameter int unsigned UNLOCK_THR = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    dn,
  input  logic                    load_en,
  input  logic [PI_BITS-1:0]      load_code,
  output logic [PI_BITS-1:0]      phase_code,
  output logic                    locked,
  output logic [1:0]              state,
  output logic                    upd,
  output logic signed [INT_W-1:0] int_out
);

  localparam int unsigned PW = PI_BITS + FRAC;
  localparam int unsigned CW = $clog2(DECIM);
  localparam int unsigned VW = CW + 2;
  localparam int unsigned SW = PW + INT_W + 8;
  localparam int unsigned AW = $clog2(ACQ_WIN + 1);
  localparam int unsigned LW = $clog2(LOCK_WIN + 1);

  localparam logic signed [INT_W:0] IntMax = {2'b00, {(INT_W - 1){1'b1}}};
  localparam logic signed [INT_W:0] IntMin = -IntMax;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StTrack  = 2'd2,
    StLocked = 2'd3
  } state_e;

  state_e                   state_q;
  logic [PW-1:0]            phase_acc_q;
  logic signed [INT_W-1:0]  int_acc_q;
  logic signed [VW-1:0]     vote_q;
  logic [CW-1:0]            win_cnt_q;
  logic [AW-1:0]            acq_cnt_q;
  logic [LW-1:0]            lock_cnt_q;
  logic                     upd_q;
  logic                     locked_q;

  logic signed [1:0]        pd;
  logic signed [VW-1:0]     win_v;
  logic [VW-1:0]            abs_v;
  logic                     win_close;
  logic                     quiet;
  logic                     loud;
  logic                     acq_last;
  logic                     lock_last;
  logic signed [INT_W:0]    int_sum;
  logic signed [INT_W-1:0]  int_sat;
  logic signed [SW-1:0]     kp_s;
  logic [PW-1:0]            ph_step;
  logic [PW-1:0]            load_val;

  always_comb begin
    pd = 2'sd0;
    if (up && !dn) begin
      pd = 2'sd1;
    end else if (!up && dn) begin
      pd = -2'sd1;
    end
  end

  // The closing cycle's own vote is part of the window sum.
  assign win_v     = vote_q + VW'(pd);
  assign abs_v     = win_v[VW-1] ? -win_v : win_v;
  assign win_close = (state_q != StIdle) && (win_cnt_q == CW'(DECIM - 1));
  assign quiet     = 32'(abs_v) <= LOCK_THR;
  assign loud      = 32'(abs_v) > UNLOCK_THR;
  assign acq_last  = (32'(acq_cnt_q) + 32'd1) == ACQ_WIN;
  assign lock_last = (32'(lock_cnt_q) + 32'd1) == LOCK_WIN;
  assign load_val  = {load_code, {FRAC{1'b0}}};

  always_comb begin
    int_sum = (INT_W + 1)'(int_acc_q) + (INT_W + 1)'(win_v);
    if (int_sum > IntMax) begin
      int_sat = IntMax[INT_W-1:0];
    end else if (int_sum < IntMin) begin
      int_sat = IntMin[INT_W-1:0];
    end else begin
      int_sat = int_sum[INT_W-1:0];
    end
  end

  // Phase step is taken modulo the accumulator width: the interpolator is circular.
  always_comb begin
    kp_s    = (state_q == StAcq) ? SW'(KP_ACQ) : SW'(KP_TRK);
    ph_step = PW'(kp_s * SW'(win_v)) + PW'(int_acc_q >>> KI_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_acc_q <= '0;
      int_acc_q   <= '0;
      vote_q      <= '0;
      win_cnt_q   <= '0;
      acq_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      upd_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (!enable) begin
        state_q    <= StIdle;
        locked_q   <= 1'b0;
        vote_q     <= '0;
        win_cnt_q  <= '0;
        acq_cnt_q  <= '0;
        lock_cnt_q <= '0;
        if (load_en) begin
          phase_acc_q <= load_val;
        end
      end else if (load_en) begin
        phase_acc_q <= load_val;
        vote_q      <= '0;
        win_cnt_q   <= '0;
      end else if (state_q == StIdle) begin
        state_q    <= StAcq;
        int_acc_q  <= '0;
        vote_q     <= '0;
        win_cnt_q  <= '0;
        acq_cnt_q  <= '0;
        lock_cnt_q <= '0;
      end else if (!win_close) begin
        vote_q    <= win_v;
        win_cnt_q <= win_cnt_q + 1'b1;
      end else begin
        vote_q      <= '0;
        win_cnt_q   <= '0;
        int_acc_q   <= int_sat;
        phase_acc_q <= phase_acc_q + ph_step;
        upd_q       <= 1'b1;
        case (state_q)
          StAcq: begin
            acq_cnt_q <= acq_cnt_q + 1'b1;
            if (acq_last) begin
              state_q <= StTrack;
            end
          end
          StTrack: begin
            if (quiet) begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
              if (lock_last) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              lock_cnt_q <= '0;
            end
          end
          StLocked: begin
            if (loud) begin
              state_q    <= StTrack;
              locked_q   <= 1'b0;
              lock_cnt_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign phase_code = phase_acc_q[PW-1:FRAC];
  assign locked     = locked_q;
  assign state      = state_q;
  assign upd        = upd_q;
  assign int_out    = int_acc_q;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// Scoreboarded bench for cdr_loop_ctrl: two instances (16-bit and 8-bit integrator) share stimulus.
module tb_cdr_loop_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, up, dn, load_en;
  logic [7:0] load_code;

  logic [7:0]         phase_code0, phase_code1;
  logic               locked0, locked1, upd0, upd1;
  logic [1:0]         state0, state1;
  logic signed [15:0] int_out0;
  logic signed [7:0]  int_out1;

  always #5 clk = ~clk;

  cdr_loop_ctrl #(.INT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .dn(dn), .load_en(load_en),
    .load_code(load_code), .phase_code(phase_code0), .locked(locked0), .state(state0),
    .upd(upd0), .int_out(int_out0)
  );

  cdr_loop_ctrl #(.INT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .dn(dn), .load_en(load_en),
    .load_code(load_code), .phase_code(phase_code1), .locked(locked1), .state(state1),
    .upd(upd1), .int_out(int_out1)
  );

  typedef struct {
    int code;
    int iv;
    int st;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];

  int n_checks = 0;
  int n_errors = 0;
  int upd_seen0 = 0;
  int cyc_n = 0;

  // Reference model state, in plain integers.
  int m_st, m_wsum, m_wn, m_acq, m_quiet;
  int m_phase[2];
  int m_int[2];
  int m_imax[2] = '{32767, 127};

  function automatic void check(string name, int got, int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endfunction

  function automatic int wrap12(int x);
    return ((x % 4096) + 4096) % 4096;
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_st = 0; m_wsum = 0; m_wn = 0; m_acq = 0; m_quiet = 0;
    m_phase = '{0, 0};
    m_int = '{0, 0};
  endtask

  task automatic model_step(input bit e, input bit u, input bit d, input bit l, input int c);
    int pdv, v, kp, s;
    exp_t x;
    pdv = (u && !d) ? 1 : ((!u && d) ? -1 : 0);
    if (!e) begin
      if (l) m_phase = '{c * 16, c * 16};
      m_st = 0; m_wsum = 0; m_wn = 0; m_acq = 0; m_quiet = 0;
      return;
    end
    if (l) begin
      m_phase = '{c * 16, c * 16};
      m_wsum = 0; m_wn = 0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1; m_int = '{0, 0}; m_wsum = 0; m_wn = 0; m_acq = 0; m_quiet = 0;
      return;
    end
    m_wsum += pdv;
    m_wn++;
    if (m_wn < 16) return;
    v = m_wsum; m_wsum = 0; m_wn = 0;
    kp = (m_st == 1) ? 4 : 1;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = wrap12(m_phase[k] + kp * v + (m_int[k] >>> 4));
      s = m_int[k] + v;
      if (s > m_imax[k]) s = m_imax[k];
      if (s < -m_imax[k]) s = -m_imax[k];
      m_int[k] = s;
    end
    case (m_st)
      1: begin m_acq++; if (m_acq == 32) m_st = 2; end
      2: begin
        if (iabs(v) <= 2) m_quiet++; else m_quiet = 0;
        if (m_quiet == 8) m_st = 3;
      end
      3: if (iabs(v) > 8) begin m_st = 2; m_quiet = 0; end
      default: ;
    endcase
    x.st = m_st;
    x.code = m_phase[0] / 16; x.iv = m_int[0]; exp0.push_back(x);
    x.code = m_phase[1] / 16; x.iv = m_int[1]; exp1.push_back(x);
  endtask

  task automatic cyc(input bit e, input bit u, input bit d, input bit l, input int c);
    enable = e; up = u; dn = d; load_en = l; load_code = 8'(c);
    @(posedge clk);
    if (rst_n) model_step(e, u, d, l, c);
    cyc_n++;
    #1;
  endtask

  // Monitor: pops the scoreboard on every update pulse and tracks the continuous outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (upd0) begin
        upd_seen0++;
        if (exp0.size() == 0) begin
          check("upd0_unexpected", 1, 0);
        end else begin
          e = exp0.pop_front();
          check("upd0_code", int'(phase_code0), e.code);
          check("upd0_int", int'(int_out0), e.iv);
          check("upd0_state", int'(state0), e.st);
          check("upd0_locked", int'(locked0), int'(e.st == 3));
        end
      end
      if (upd1) begin
        if (exp1.size() == 0) begin
          check("upd1_unexpected", 1, 0);
        end else begin
          e = exp1.pop_front();
          check("upd1_code", int'(phase_code1), e.code);
          check("upd1_int", int'(int_out1), e.iv);
        end
      end
      check("state_track", int'(state0), m_st);
      check("code_track0", int'(phase_code0), m_phase[0] / 16);
      check("code_track1", int'(phase_code1), m_phase[1] / 16);
      check("locked_track", int'(locked0), int'(m_st == 3));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int code_hold, upd_before, mode;
    bit u, d, e, l;
    rst_n = 1'b0; enable = 0; up = 0; dn = 0; load_en = 0; load_code = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_code", int'(phase_code0), 0);
    check("reset_int", int'(int_out0), 0);
    check("reset_state", int'(state0), 0);
    check("reset_locked", int'(locked0), 0);
    check("reset_upd", int'(upd0), 0);
    #2 rst_n = 1'b1;

    // Acquisition slope with a constant up vote.
    cyc(1, 0, 0, 0, 0);
    repeat (16) cyc(1, 1, 0, 0, 0);
    check("slope1_code", int'(phase_code0), 4);
    check("slope1_int", int'(int_out0), 16);
    check("slope1_upd", int'(upd0), 1);
    repeat (16) cyc(1, 1, 0, 0, 0);
    check("slope2_code", int'(phase_code0), 8);
    check("slope2_int", int'(int_out0), 32);
    cyc(0, 0, 0, 0, 0);
    check("disable_state", int'(state0), 0);

    // Neutral votes: code and integrator stay put while updates keep pulsing.
    cyc(1, 0, 0, 0, 0);
    upd_before = upd_seen0;
    repeat (160) cyc(1, 1, 1, 0, 0);
    @(negedge clk); #1;
    check("neutral_code", int'(phase_code0), 8);
    check("neutral_int", int'(int_out0), 0);
    check("neutral_upd_count", upd_seen0 - upd_before, 10);

    // Lock sequence with alternating votes, then a loud window.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (31 * 16) cyc(1, cyc_n[0], !cyc_n[0], 0, 0);
    check("acq_w31_state", int'(state0), 1);
    repeat (16) cyc(1, cyc_n[0], !cyc_n[0], 0, 0);
    check("track_w32_state", int'(state0), 2);
    repeat (7 * 16) cyc(1, cyc_n[0], !cyc_n[0], 0, 0);
    check("track_w39_state", int'(state0), 2);
    repeat (16) cyc(1, cyc_n[0], !cyc_n[0], 0, 0);
    check("lock_w40_state", int'(state0), 3);
    check("lock_w40_locked", int'(locked0), 1);
    repeat (16) cyc(1, 1, 0, 0, 0);
    check("unlock_state", int'(state0), 2);
    check("unlock_locked", int'(locked0), 0);

    // Wrap through the top of the code range.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 255);
    check("load_code", int'(phase_code0), 255);
    repeat (16) cyc(1, 1, 0, 0, 0);
    check("wrap_code0", int'(phase_code0), 3);
    check("wrap_code1", int'(phase_code1), 3);
    check("wrap_int", int'(int_out0), 16);

    // Saturation of the 8-bit integrator.
    repeat (6 * 16) cyc(1, 1, 0, 0, 0);
    check("sat_w7", int'(int_out1), 112);
    repeat (16) cyc(1, 1, 0, 0, 0);
    check("sat_w8", int'(int_out1), 127);
    repeat (2 * 16) cyc(1, 1, 0, 0, 0);
    check("sat_w10", int'(int_out1), 127);
    check("nosat_w10", int'(int_out0), 160);

    // Abort mid-window: no update, state back to idle, code held.
    repeat (8) cyc(1, 1, 0, 0, 0);
    code_hold = int'(phase_code0);
    cyc(0, 1, 0, 0, 0);
    check("abort_state", int'(state0), 0);
    check("abort_upd", int'(upd0), 0);
    check("abort_code", int'(phase_code0), code_hold);

    // Enable fall together with a load.
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 8'hA5);
    check("fall_load_state", int'(state0), 0);
    check("fall_load_code", int'(phase_code0), 8'hA5);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) begin
        case (mode)
          0: begin u = cyc_n[0]; d = !cyc_n[0]; end
          1: begin u = ($urandom_range(0, 3) != 0); d = !u; end
          default: begin u = 1'($urandom); d = 1'($urandom); end
        endcase
        e = ($urandom_range(0, 1499) != 0);
        l = ($urandom_range(0, 149) == 0);
        cyc(e, u, d, l, $urandom_range(0, 255));
      end
    end

    // Asynchronous reset in the middle of a window.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 8'h5A);
    repeat (5) cyc(1, 1, 0, 0, 0);
    check("pre_reset_code", int'(phase_code0), 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check("async_code", int'(phase_code0), 0);
    check("async_int", int'(int_out0), 0);
    check("async_state", int'(state0), 0);
    check("async_locked", int'(locked0), 0);
    check("async_upd", int'(upd0), 0);
    model_reset();
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc(1, 1, 0, 0, 0);
    @(negedge clk); #1;
    check("drain0", exp0.size(), 0);
    check("drain1", exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdr_loop_ctrl.md
Name: cdr_loop_ctrl

Overview:
- Digital CDR loop controller. Consumes the bang-bang phase detector's up/dn votes, decimates them over fixed windows, and runs a proportional-integral loop filter.
- Drives the phase code of the sampling-clock phase interpolator.
- Sequences acquisition, tracking and lock detection. Supports a direct phase-load override for calibration.

Parameters:
- PI_BITS, 8: phase interpolator code width.
- FRAC, 4: fractional bits of the phase accumulator below the code.
- DECIM, 16: PD cycles per vote window (power of two, 2..256).
- INT_W, 16: signed integrator width.
- KP_ACQ, 4: proportional gain in acquisition (frac LSBs per vote).
- KP_TRK, 1: proportional gain in track and locked states.
- KI_SHIFT, 4: integrator contribution is int_acc arithmetically shifted right by KI_SHIFT.
- ACQ_WIN, 32: windows spent in acquisition.
- LOCK_THR, 2: |V| at or below this counts as a quiet window.
- LOCK_WIN, 8: consecutive quiet windows needed to declare lock.
- UNLOCK_THR, 8: |V| above this while locked drops lock.

Ports:
- clk, in, 1: PD clock (same edge as PD outputs).
- rst_n, in, 1: reset, asynchronous, active-low.
- enable, in, 1: loop enable.
- up, in, 1: PD up vote.
- dn, in, 1: PD down vote.
- load_en, in, 1: phase override strobe.
- load_code, in, PI_BITS: override code.
- phase_code, out, PI_BITS: phase interpolator code, equal to phase_acc[PI_BITS+FRAC-1:FRAC].
- locked, out, 1: lock indicator.
- state, out, 2: 0 IDLE, 1 ACQ, 2 TRACK, 3 LOCKED.
- upd, out, 1: one-cycle pulse on each applied window update.
- int_out, out, INT_W: integrator value.

Behaviour:
- Reset (async on rst_n low): phase_acc=0, int_acc=0, vote=0, win_cnt=0, acq_cnt=0, lock_cnt=0, state=IDLE. All outputs are 0.
- Per-cycle PD value pd:
  - up=1, dn=0 gives +1.
  - up=0, dn=1 gives -1.
  - Equal inputs give 0.
- Window accumulation:
  - vote accumulates pd while state is not IDLE. win_cnt counts 0..DECIM-1.
  - On the edge where win_cnt==DECIM-1, the window closes with V = vote+pd (this cycle's pd is included). On that same edge vote clears and win_cnt returns to 0.
- Update, registered on the closing edge:
  - int_acc <= sat(int_acc+V), saturating at ±(2^(INT_W-1)-1). It never wraps.
  - phase_acc <= phase_acc + KP*V + (old int_acc >>> KI_SHIFT), modulo 2^(PI_BITS+FRAC). phase_acc wraps because the interpolator is circular.
  - KP is KP_ACQ in ACQ and KP_TRK otherwise.
  - upd is high for the following cycle.
  - Positive V advances the code.
- State machine, evaluated on the window-close edge unless noted:
  - IDLE: phase_acc held, int_acc held. When enable=1, go to ACQ on the next edge, clearing int_acc, vote, win_cnt, acq_cnt and lock_cnt.
  - ACQ: acq_cnt increments per window. The window where acq_cnt reaches ACQ_WIN moves to TRACK.
  - TRACK:
    - Quiet window (|V|<=LOCK_THR): lock_cnt+1. Any other window: lock_cnt=0.
    - lock_cnt reaching LOCK_WIN moves to LOCKED; locked=1 from that edge.
  - LOCKED: |V|>UNLOCK_THR moves to TRACK, locked=0, lock_cnt=0.
  - enable=0 in any state: IDLE on the next edge. vote, win_cnt and counters clear; phase_acc and int_acc are held; locked=0; any in-progress window is discarded with no upd.
- Override: load_en=1 (any state) sets phase_acc={load_code, FRAC zeros}, clears vote and win_cnt, and suppresses any window update on that edge. State, int_acc and counters are unchanged. load_en has priority over the window update.
- Simultaneous enable fall and load_en: load applies, and the state goes to IDLE.
- Latency: phase_code reflects a window's votes on the edge the window closes; upd follows one cycle later.

Test Plan:
- Acquisition slope: reset, enable=1, up=1, dn=0 constant.
  - First upd gives phase_code=4, int_out=16.
  - Second upd gives phase_acc=129, phase_code=8, int_out=32.
- Lock sequence: enable, up/dn alternating each cycle (V=0).
  - state becomes TRACK after window 32.
  - state becomes LOCKED with locked=1 after window 40.
  - One window with up constant (V=16) returns state to TRACK with locked=0.
- Wrap: load_en with load_code=255, state ACQ, int_acc=0, V=+16 → phase_code=3 (4144 mod 4096 = 48), no saturation.
- Saturation with INT_W=8: up constant → int_out=112 after 7 windows, 127 after 8 windows, and it stays at 127.
- Neutral votes: up=dn=1 for 10 windows → phase_code and int_out unchanged, upd still pulses.
- Abort and reset:
  - enable dropped mid-window → no upd, state IDLE, phase_code held.
  - rst_n low mid-window → all outputs 0 immediately, without waiting for a clock edge.
